// File: rtl/cpu_boot_system.sv
// Processor subsystem with a byte-stream boot loader: frames fill program or
// data memory while the core is held in reset; a completed code frame releases it.

module bsram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  // No reset on purpose: contents survive a subsystem reset.
  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// state   | meaning
// C_FETCH | program address presented, instruction arrives next cycle
// C_EXEC  | decode/execute instruction, advance pc
// C_LOAD  | data-memory read word arrives, latch into acc
// C_HALT  | stopped until resume
module cpu #(
  parameter int CODE_WIDTH = 13,
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  resume,
  output logic [CODE_WIDTH-1:0] i_addr,
  input  logic [15:0]           i_data,
  output logic [DATA_WIDTH-1:0] d_addr,
  output logic [15:0]           d_wdata,
  output logic                  d_we,
  input  logic [15:0]           d_rdata
);
  typedef enum logic [1:0] {C_FETCH, C_EXEC, C_LOAD, C_HALT} cpu_state_t;

  cpu_state_t            state, state_nxt;
  logic [CODE_WIDTH-1:0] pc, pc_nxt;
  logic [15:0]           acc, acc_nxt;
  logic [3:0]            op;
  logic [11:0]           imm;

  assign op     = i_data[15:12];
  assign imm    = i_data[11:0];
  assign i_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= C_FETCH;
      pc    <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      acc   <= acc_nxt;
    end
  end

  // ISA: 1=LDI imm, 2=ST [imm], 3=LD [imm], 4=ADD imm, F=HALT, others NOP.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    d_addr    = DATA_WIDTH'(imm);
    d_wdata   = acc;
    d_we      = 1'b0;
    case (state)
      C_FETCH: state_nxt = C_EXEC;
      C_EXEC: begin
        pc_nxt    = pc + 1'b1;
        state_nxt = C_FETCH;
        case (op)
          4'h1: acc_nxt = {4'h0, imm};
          4'h2: d_we = 1'b1;
          4'h3: state_nxt = C_LOAD;
          4'h4: acc_nxt = acc + {4'h0, imm};
          4'hf: state_nxt = C_HALT;
          default: ;
        endcase
      end
      C_LOAD: begin
        acc_nxt   = d_rdata;
        state_nxt = C_FETCH;
      end
      C_HALT: if (resume) state_nxt = C_FETCH;
      default: state_nxt = C_FETCH;
    endcase
  end
endmodule

// state   | meaning
// SYNC    | waiting for 0xA5
// TARGET  | target byte: 0x00 code, 0x01 data
// CNT_HI  | word count high byte
// CNT_LO  | word count low byte
// DATA_HI | word high byte
// DATA_LO | word low byte, write issued
// LAST    | final code word being written; bytes ignored
// RUN     | core released, loader retired
module cpu_boot_system #(
  parameter int CODE_WIDTH = 13,
  parameter int DATA_WIDTH = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resume,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       running,
  output logic       sync_err
);
  localparam int AW = (CODE_WIDTH > DATA_WIDTH) ? CODE_WIDTH : DATA_WIDTH;

  typedef enum logic [2:0] {SYNC, TARGET, CNT_HI, CNT_LO, DATA_HI, DATA_LO, LAST, RUN} ld_state_t;

  ld_state_t       state, state_nxt;
  logic            accept, bad_byte;
  logic            tgt_data;
  logic [15:0]     count;
  logic [AW-1:0]   addr, wr_addr;
  logic [7:0]      hi_byte;
  logic [15:0]     wr_data;
  logic            prog_we, data_we;

  logic [CODE_WIDTH-1:0] core_i_addr;
  logic [15:0]           core_i_data, core_d_wdata, core_d_rdata;
  logic [DATA_WIDTH-1:0] core_d_addr, dmem_waddr;
  logic                  core_d_we, core_reset, dmem_we;
  logic [15:0]           dmem_wdata;

  assign accept = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    bad_byte  = 1'b0;
    case (state)
      SYNC: if (accept) begin
        if (load_data == 8'hA5) state_nxt = TARGET;
        else                    bad_byte  = 1'b1;
      end
      TARGET: if (accept) begin
        if (load_data[7:1] == 7'd0) begin
          state_nxt = CNT_HI;
        end else begin
          bad_byte  = 1'b1;
          state_nxt = SYNC;
        end
      end
      CNT_HI: if (accept) state_nxt = CNT_LO;
      CNT_LO: if (accept) begin
        if ({count[15:8], load_data} == 16'd0) state_nxt = tgt_data ? SYNC : RUN;
        else                                   state_nxt = DATA_HI;
      end
      DATA_HI: if (accept) state_nxt = DATA_LO;
      DATA_LO: if (accept) begin
        if (count == 16'd1) state_nxt = tgt_data ? SYNC : LAST;
        else                state_nxt = DATA_HI;
      end
      LAST:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      load_ready <= 1'b1;
      running    <= 1'b0;
      sync_err   <= 1'b0;
      tgt_data   <= 1'b0;
      count      <= '0;
      addr       <= '0;
      hi_byte    <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      prog_we    <= 1'b0;
      data_we    <= 1'b0;
    end else begin
      state      <= state_nxt;
      load_ready <= (state_nxt != RUN);
      running    <= (state_nxt == RUN);
      prog_we    <= 1'b0;
      data_we    <= 1'b0;
      if (bad_byte) sync_err <= 1'b1;
      if (accept) begin
        case (state)
          TARGET: if (load_data[7:1] == 7'd0) tgt_data <= load_data[0];
          CNT_HI: count[15:8] <= load_data;
          CNT_LO: begin
            count[7:0] <= load_data;
            addr       <= '0;
          end
          DATA_HI: hi_byte <= load_data;
          DATA_LO: begin
            wr_data <= {hi_byte, load_data};
            wr_addr <= addr;
            addr    <= addr + 1'b1;
            count   <= count - 1'b1;
            prog_we <= !tgt_data;
            data_we <= tgt_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Data-memory write port belongs to the loader until running, then the core.
  always_comb begin
    dmem_we    = data_we;
    dmem_waddr = wr_addr[DATA_WIDTH-1:0];
    dmem_wdata = wr_data;
    if (running) begin
      dmem_we    = core_d_we;
      dmem_waddr = core_d_addr;
      dmem_wdata = core_d_wdata;
    end
  end

  assign core_reset = !running;

  bsram #(.AW(CODE_WIDTH)) u_prog (
    .clk   (clk),
    .we    (prog_we),
    .waddr (wr_addr[CODE_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (core_i_addr),
    .rdata (core_i_data)
  );

  bsram #(.AW(DATA_WIDTH)) u_data (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (core_d_addr),
    .rdata (core_d_rdata)
  );

  cpu #(.CODE_WIDTH(CODE_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cpu (
    .clk     (clk),
    .reset   (core_reset),
    .resume  (resume),
    .i_addr  (core_i_addr),
    .i_data  (core_i_data),
    .d_addr  (core_d_addr),
    .d_wdata (core_d_wdata),
    .d_we    (core_d_we),
    .d_rdata (core_d_rdata)
  );
endmodule

// File: tb/tb_cpu_boot_system.sv
// Directed bench for cpu_boot_system: boot frames, error handling, wrap,
// mid-frame reset and core ownership of data memory after release.

module tb_cpu_boot_system;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       resume = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready, running, sync_err;
  logic       load_ready_w, running_w, sync_err_w;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [2:0] exp;   // {load_ready, running, sync_err}
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  cpu_boot_system dut (
    .clk        (clk),
    .reset      (reset),
    .resume     (resume),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .running    (running),
    .sync_err   (sync_err)
  );

  cpu_boot_system #(.CODE_WIDTH(2), .DATA_WIDTH(13)) dut_w (
    .clk        (clk),
    .reset      (reset),
    .resume     (resume),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready_w),
    .running    (running_w),
    .sync_err   (sync_err_w)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_q();
    foreach (q[i]) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = q[i];
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    load_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 3'b100};
    vecs[1]  = '{1'b1, 8'h3C, 3'b101};
    vecs[2]  = '{1'b0, 8'h00, 3'b101};
    vecs[3]  = '{1'b1, 8'hA5, 3'b101};
    vecs[4]  = '{1'b1, 8'h07, 3'b101};
    vecs[5]  = '{1'b1, 8'hA5, 3'b101};
    vecs[6]  = '{1'b1, 8'h00, 3'b101};
    vecs[7]  = '{1'b1, 8'h00, 3'b101};
    vecs[8]  = '{1'b1, 8'h01, 3'b101};
    vecs[9]  = '{1'b0, 8'h00, 3'b101};
    vecs[10] = '{1'b1, 8'h00, 3'b101};
    vecs[11] = '{1'b1, 8'h01, 3'b101};
    vecs[12] = '{1'b0, 8'h00, 3'b011};

    #1 reset = 1'b0;
    #3;
    chk("reset outputs", {13'd0, load_ready, running, sync_err}, 16'b100);
    chk("reset outputs w", {13'd0, load_ready_w, running_w, sync_err_w}, 16'b100);
    @(negedge clk);
    reset = 1'b1;

    // Code frame with valid held high.
    q = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_q();
    chk("t1 running before release", {15'd0, running}, 16'd0);
    chk("t1 ready before release", {15'd0, load_ready}, 16'd1);
    idle(1);
    chk("t1 running", {15'd0, running}, 16'd1);
    chk("t1 ready", {15'd0, load_ready}, 16'd0);
    chk("t1 sync_err", {15'd0, sync_err}, 16'd0);
    chk("t1 prog0", dut.u_prog.mem[0], 16'h1234);
    chk("t1 prog1", dut.u_prog.mem[1], 16'hABCD);

    // Data frame then empty code frame.
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'hBE, 8'hEF};
    send_q();
    idle(1);
    chk("t2 running after data", {15'd0, running}, 16'd0);
    chk("t2 data0", dut.u_data.mem[0], 16'hBEEF);
    q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    chk("t2 running at N=0", {15'd0, running}, 16'd1);
    chk("t2 ready at N=0", {15'd0, load_ready}, 16'd0);
    chk("t2 prog0 untouched", dut.u_prog.mem[0], 16'h1234);
    chk("t2 prog1 untouched", dut.u_prog.mem[1], 16'hABCD);

    // Bad sync / bad target stream, table driven.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      load_valid = vecs[i].valid;
      load_data  = vecs[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rdy/run/err", i), {13'd0, load_ready, running, sync_err},
          {13'd0, vecs[i].exp});
    end
    chk("t3 prog0", dut.u_prog.mem[0], 16'h0001);

    // Address wrap on the 4-word program memory instance.
    do_reset();
    q = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'h02,
          8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
    send_q();
    idle(1);
    chk("t4 running w", {15'd0, running_w}, 16'd1);
    chk("t4 wrap0", dut_w.u_prog.mem[0], 16'h0005);
    chk("t4 wrap1", dut_w.u_prog.mem[1], 16'h0002);
    chk("t4 wrap2", dut_w.u_prog.mem[2], 16'h0003);
    chk("t4 wrap3", dut_w.u_prog.mem[3], 16'h0004);
    chk("t4 nowrap4", dut.u_prog.mem[4], 16'h0005);

    // Reset mid-frame, with a write registered but not yet performed.
    do_reset();
    q = '{8'h3C, 8'hA5, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34};
    send_q();
    chk("t5 sync_err before reset", {15'd0, sync_err}, 16'd1);
    reset = 1'b0;
    #1;
    chk("t5 outputs in reset", {13'd0, load_ready, running, sync_err}, 16'b100);
    @(posedge clk);
    #1;
    chk("t5 aborted write", dut.u_prog.mem[0], 16'h0001);
    @(negedge clk);
    reset = 1'b1;
    q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h55, 8'hAA};
    send_q();
    idle(1);
    chk("t5 prog0", dut.u_prog.mem[0], 16'h55AA);
    chk("t5 running", {15'd0, running}, 16'd1);

    // Core ownership of data memory after release.
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h11, 8'h11, 8'h22, 8'h22, 8'h00, 8'h00};
    send_q();
    idle(3);
    chk("t6 data3 before run", dut.u_data.mem[3], 16'h1111);
    chk("t6 held core", {15'd0, running}, 16'd0);
    q = '{8'hA5, 8'h00, 8'h00, 8'h09,
          8'h10, 8'h42, 8'h20, 8'h03, 8'hF0, 8'h00, 8'h40, 8'h01, 8'h20, 8'h04,
          8'h30, 8'h03, 8'h40, 8'h02, 8'h20, 8'h05, 8'hF0, 8'h00};
    send_q();
    idle(1);
    chk("t6 running", {15'd0, running}, 16'd1);
    q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h99, 8'h99};
    send_q();
    chk("t6 ready in run", {15'd0, load_ready}, 16'd0);
    chk("t6 prog0 kept", dut.u_prog.mem[0], 16'h1042);
    chk("t6 prog1 kept", dut.u_prog.mem[1], 16'h2003);
    idle(30);
    chk("t6 core store", dut.u_data.mem[3], 16'h0042);
    chk("t6 halted", dut.u_data.mem[4], 16'h2222);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    idle(40);
    chk("t6 after resume add", dut.u_data.mem[4], 16'h0043);
    chk("t6 after resume load", dut.u_data.mem[5], 16'h0044);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_boot_system.md
# cpu_boot_system

Self-contained processor subsystem: `cpu`, a data `bsram` and a program `bsram`, plus a byte-stream boot loader that fills either memory before the core runs. After reset the core is held in reset while frames arrive on a valid/ready byte port. Completing a code frame releases the core, and from then on the core owns both memories. It replaces the fixed-image system top so that programs and initial data can be delivered at run time.

## Interface
- `CODE_WIDTH`, 13, program-memory word-address width; depth 2^CODE_WIDTH words of 16 bits.
- `DATA_WIDTH`, 13, data-memory word-address width; depth 2^DATA_WIDTH words of 16 bits.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset of the whole block.
- `resume`  in  1  passed unchanged to `cpu.resume`.
- `load_valid`  in  1  byte on `load_data` is offered.
- `load_data`  in  8  boot-stream byte.
- `load_ready`  out  1  loader can accept a byte this cycle.
- `running`  out  1  core released; loader retired.
- `sync_err`  out  1  sticky: a bad sync byte or bad target byte was seen.

## Operation
- Byte transfer: a byte is accepted on a rising edge where `load_valid && load_ready`.
- Frame format, in order:
  - `0xA5` sync byte;
  - target byte (`0x00` = code, `0x01` = data);
  - word count N, high byte then low byte;
  - N words, each high byte then low byte.
- Words are written at addresses 0, 1, 2, … of the target memory. Addresses wrap modulo the memory depth, so when N exceeds the depth, later words overwrite earlier ones.
- FSM states: SYNC → TARGET → CNT_HI → CNT_LO → DATA_HI → DATA_LO → (DATA_HI | SYNC | RUN).
  - SYNC: byte `0xA5` → TARGET. Any other byte sets `sync_err` and stays in SYNC.
  - TARGET: `0x00` or `0x01` latched as the target → CNT_HI. Any other value sets `sync_err` → SYNC.
  - CNT_LO: N==0 → RUN for a code target, SYNC for a data target. Otherwise → DATA_HI with the address counter cleared.
  - DATA_LO: issue the write, increment the address, decrement the remaining count. Count reaches 0 → RUN for code, SYNC for data; otherwise → DATA_HI.
  - RUN: terminal until reset. `load_ready`=0 and stream bytes are ignored.
- Any number of data frames may precede the code frame. A data frame received after a code frame is impossible, because RUN is terminal.
- Memory port muxing:
  - Before RUN, the loader drives the write port of the selected memory. The program memory write port is used only by the loader.
  - The core's data-memory write enable is gated to 0 while not `running`.
  - In RUN, the core owns the data-memory write port and the loader's write enables are held at 0.
- Core reset: `cpu.reset` is asserted (active-high) whenever `running`=0, including while `reset` is low.

## Timing
- Reset values (while `reset`=0, asynchronously): state=SYNC, `load_ready`=1, `running`=0, `sync_err`=0, address/count/target registers 0, loader write enables 0.
- `load_ready` is a registered decode of state: 1 in every state except RUN. The loader never back-pressures before RUN.
- Write latency: the low byte of a word is accepted at edge k. The write enable, address and data are registered and valid during cycle k→k+1, and memory is written at edge k+1.
- Release: for the final word accepted at edge k, `running` rises after edge k+1 (same edge as the last write). The core leaves reset on the following cycle.
- For a code frame with N==0 accepted at edge k (CNT_LO), `running` rises after edge k.
- `sync_err` sets at the edge that accepts the offending byte and holds until `reset`.
- Gaps (`load_valid`=0) in any state leave all registers unchanged.
- Reset asserted mid-frame: everything returns to its reset values immediately, including mid-write. Memory contents already written are retained, because `bsram` has no reset.
- Width rules:
  - The count is 16 bits.
  - The address counter is CODE_WIDTH or DATA_WIDTH bits wide and wraps silently.
  - Words are assembled as {high byte, low byte}.

## Test plan
- Code frame A5 00 00 02 12 34 AB CD, with `load_valid` held high → program mem[0]=0x1234, mem[1]=0xABCD. `running` rises one edge after the `CD` byte; `load_ready` falls with it; `sync_err`=0.
- Data frame A5 01 00 01 BE EF, then code frame A5 00 00 00 → data mem[0]=0xBEEF, program memory untouched. `running` rises at the edge accepting the final `00`.
- Stream 3C A5 07 A5 00 00 01 00 01 → `sync_err`=1 after the `3C`. The `07` target is rejected back to SYNC. Program mem[0]=0x0001 and `running`=1.
- Wrap with CODE_WIDTH=2: code frame of N=5 words 1..5 → mem[0]=5, mem[1]=2, mem[2]=3, mem[3]=4.
- `reset` pulsed low after the A5 00 00 03 12 34 bytes of a frame → outputs return to reset values immediately. Afterwards a fresh A5 00 00 01 55 AA loads program mem[0]=0x55AA and asserts `running`.
- After `running`=1, offer bytes with `load_valid`=1 → none accepted and no loader writes occur. Core writes to data memory succeed; core writes attempted before `running` leave data memory unchanged.
